// File: rtl/uart_hex_sender.sv
// uart_hex_sender: serialises 32-bit read-back words to the UART TX byte stream as 8 ASCII hex chars plus a separator
module uart_hex_sender #(
    parameter int WORDS_PER_LINE = 4,
    parameter bit UPPER_HEX      = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdata_snd_start,
    input  logic [31:0] rdata_snd,
    input  logic        read_stop,
    input  logic        line_clear,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        flushing_wq,
    output logic        sender_busy,
    output logic        overflow
);
    localparam int LW = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1;
    localparam logic [LW-1:0] LAST = LW'(WORDS_PER_LINE - 1);
    localparam logic [2:0] IDLE = 3'd0, CHAR = 3'd1, SEP = 3'd2, CR = 3'd3, LF = 3'd4, DONE = 3'd5;
    logic [2:0]    state_q, state_d;
    logic [31:0]   shreg_q, shreg_d, pend_q, pend_d;
    logic          pend_full_q, pend_full_d, abort_q, abort_d, ovf_q, ovf_d;
    logic [2:0]    nib_q, nib_d;
    logic [LW-1:0] line_q, line_d;
    logic [3:0]    nib;
    logic [7:0]    hex_c;
    logic          idle, accept, stop;
    assign idle        = state_q == IDLE;
    assign tx_valid    = state_q == CHAR || state_q == SEP || state_q == CR || state_q == LF;
    assign accept      = tx_valid & tx_ready;
    assign stop        = read_stop & ~idle;
    assign nib         = shreg_q[31:28];
    assign hex_c       = nib < 4'd10 ? 8'h30 + {4'h0, nib} : (UPPER_HEX ? 8'h37 : 8'h57) + {4'h0, nib};
    assign tx_data     = state_q == CHAR ? hex_c :
                         state_q == SEP  ? 8'h20 :
                         state_q == CR   ? 8'h0D :
                         state_q == LF   ? 8'h0A : 8'h00;
    assign flushing_wq = state_q == DONE;
    assign sender_busy = ~idle | pend_full_q;
    assign overflow    = ovf_q;
    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        nib_d       = nib_q;
        line_d      = line_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        abort_d     = abort_q;
        ovf_d       = ovf_q;
        if (idle) begin
            // a word parked in the pending slot is served before a fresh start, which then takes its place
            if (pend_full_q) begin
                shreg_d     = pend_q;
                nib_d       = 3'd7;
                state_d     = CHAR;
                pend_d      = rdata_snd;
                pend_full_d = rdata_snd_start;
            end else if (rdata_snd_start) begin
                shreg_d = rdata_snd;
                nib_d   = 3'd7;
                state_d = CHAR;
            end
        end else if (stop) begin
            pend_full_d = 1'b0;
            line_d      = '0;
            abort_d     = tx_valid & ~tx_ready;
            state_d     = abort_d ? state_q : IDLE;
        end else begin
            if (rdata_snd_start) begin
                pend_d      = pend_full_q ? pend_q : rdata_snd;
                pend_full_d = 1'b1;
                ovf_d       = ovf_q | pend_full_q;
            end
            if (abort_q) begin
                state_d = accept ? IDLE : state_q;
                abort_d = ~accept;
            end else if (state_q == DONE) begin
                state_d = IDLE;
                line_d  = line_q == LAST ? '0 : line_q + LW'(1);
            end else if (accept) begin
                case (state_q)
                    CHAR: begin
                        shreg_d = {shreg_q[27:0], 4'h0};
                        nib_d   = nib_q - 3'd1;
                        state_d = nib_q != 3'd0 ? CHAR : line_q == LAST ? CR : SEP;
                    end
                    CR:      state_d = LF;
                    default: state_d = DONE;
                endcase
            end
        end
        if (line_clear) begin
            line_d = '0;
            ovf_d  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            abort_q     <= 1'b0;
            ovf_q       <= 1'b0;
            nib_q       <= '0;
            line_q      <= '0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            abort_q     <= abort_d;
            ovf_q       <= ovf_d;
            nib_q       <= nib_d;
            line_q      <= line_d;
        end
    end
endmodule

// File: tb/tb_uart_hex_sender.sv
// tb_uart_hex_sender: directed vector table plus hand-written abort/overflow/reset sequences for uart_hex_sender
module tb_uart_hex_sender;
    logic        clk = 1'b0, rst = 1'b1, rdata_snd_start = 1'b0, read_stop = 1'b0, line_clear = 1'b0, tx_ready = 1'b0;
    logic [31:0] rdata_snd = '0;
    logic        tx_valid, flushing_wq, sender_busy, overflow;
    logic [7:0]  tx_data;
    int          errors = 0, checks = 0, cyc = 0, rdy_per = 1, first_v = -1;
    logic        prev_v = 1'b0;
    logic [7:0]  prev_d = '0;
    logic [7:0]  got[$];
    int          flush_at[$];
    typedef struct {
        logic [31:0] word;
        int          rdy;
        int          nb;
        logic [79:0] bytes;
        int          lat;
    } vec_t;
    vec_t vecs[5];
    uart_hex_sender #(.WORDS_PER_LINE(4), .UPPER_HEX(1'b0)) dut (
        .clk(clk), .rst(rst), .rdata_snd_start(rdata_snd_start), .rdata_snd(rdata_snd),
        .read_stop(read_stop), .line_clear(line_clear), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .flushing_wq(flushing_wq), .sender_busy(sender_busy), .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    // one cycle: drive tx_ready for this cycle, then observe the state-driven outputs
    task automatic step();
        @(negedge clk);
        cyc++;
        tx_ready = rdy_per == 0 ? 1'b0 : (cyc % rdy_per == 0);
        if (prev_v) begin
            chk("hold_valid", 32'(tx_valid), 32'd1);
            chk("hold_data", 32'(tx_data), 32'(prev_d));
        end
        if (tx_valid && first_v < 0) first_v = cyc;
        if (tx_valid && tx_ready) got.push_back(tx_data);
        if (flushing_wq) flush_at.push_back(cyc);
        prev_v = tx_valid & ~tx_ready;
        prev_d = tx_data;
    endtask
    task automatic begin_seq();
        cyc = 0;
        first_v = -1;
        got.delete();
        flush_at.delete();
    endtask
    task automatic start(input logic [31:0] w);
        rdata_snd_start = 1'b1;
        rdata_snd = w;
        step();
        rdata_snd_start = 1'b0;
    endtask
    task automatic check_bytes(input string name, input int off, input int nb, input logic [79:0] bytes);
        for (int i = 0; i < nb; i++)
            chk($sformatf("%s_byte%0d", name, off + i),
                off + i < got.size() ? 32'(got[off + i]) : 32'hFFFF_FFFF, 32'(bytes[8*(nb-1-i) +: 8]));
    endtask
    task automatic check_outputs_zero(input string name);
        chk({name, "_valid"}, 32'(tx_valid), 32'd0);
        chk({name, "_data"}, 32'(tx_data), 32'd0);
        chk({name, "_flush"}, 32'(flushing_wq), 32'd0);
        chk({name, "_busy"}, 32'(sender_busy), 32'd0);
        chk({name, "_ovf"}, 32'(overflow), 32'd0);
    endtask
    task automatic run_vec(input string name, input vec_t t);
        begin_seq();
        rdy_per = t.rdy;
        start(t.word);
        while (flush_at.size() == 0 && cyc < 200) step();
        chk({name, "_flush_seen"}, 32'(flush_at.size()), 32'd1);
        if (t.lat != 0) chk({name, "_flush_cycle"}, flush_at.size() > 0 ? 32'(flush_at[0]) : 32'hFFFF_FFFF, 32'(t.lat));
        if (t.rdy == 1) chk({name, "_first_valid"}, 32'(first_v), 32'd1);
        chk({name, "_count"}, 32'(got.size()), 32'(t.nb));
        check_bytes(name, 0, t.nb, t.bytes);
        rdy_per = 1;
        step();
    endtask
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        vecs[0] = '{32'h1234ABCD, 1, 9,  80'h00_31_32_33_34_61_62_63_64_20, 10};
        vecs[1] = '{32'h00000000, 1, 9,  80'h00_30_30_30_30_30_30_30_30_20, 10};
        vecs[2] = '{32'hFFFFFFFF, 1, 9,  80'h00_66_66_66_66_66_66_66_66_20, 10};
        vecs[3] = '{32'h9A5F0E71, 1, 10, 80'h39_61_35_66_30_65_37_31_0D_0A, 11};
        vecs[4] = '{32'hDEADBEEF, 3, 9,  80'h00_64_65_61_64_62_65_65_66_20, 0};
        rdy_per = 1;
        repeat (3) step();
        check_outputs_zero("reset");
        rst = 1'b0;
        step();
        for (int v = 0; v < 5; v++) run_vec($sformatf("vec%0d", v), vecs[v]);
        // back-to-back starts: second parks in the slot, third is dropped
        line_clear = 1'b1;
        step();
        line_clear = 1'b0;
        begin_seq();
        start(32'h11111111);
        start(32'h22222222);
        start(32'h33333333);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_busy", 32'(sender_busy), 32'd1);
        while (cyc < 30) step();
        chk("ovf_flush_count", 32'(flush_at.size()), 32'd2);
        chk("ovf_flush0", flush_at.size() > 0 ? 32'(flush_at[0]) : 32'hFFFF_FFFF, 32'd10);
        chk("ovf_flush1", flush_at.size() > 1 ? 32'(flush_at[1]) : 32'hFFFF_FFFF, 32'd21);
        chk("ovf_count", 32'(got.size()), 32'd18);
        check_bytes("ovf_w1", 0, 9, 80'h00_31_31_31_31_31_31_31_31_20);
        check_bytes("ovf_w2", 9, 9, 80'h00_32_32_32_32_32_32_32_32_20);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        line_clear = 1'b1;
        step();
        line_clear = 1'b0;
        chk("ovf_cleared", 32'(overflow), 32'd0);
        // abort while nibble 3 is held un-accepted, with a word waiting in the slot
        begin_seq();
        start(32'hCAFE1234);
        step();
        start(32'h55555555);
        step();
        rdy_per = 0;
        step();
        chk("abort_held_valid", 32'(tx_valid), 32'd1);
        chk("abort_held_data", 32'(tx_data), 32'h31);
        read_stop = 1'b1;
        step();
        read_stop = 1'b0;
        step();
        rdy_per = 1;
        step();
        step();
        chk("abort_idle_valid", 32'(tx_valid), 32'd0);
        chk("abort_idle_busy", 32'(sender_busy), 32'd0);
        repeat (12) step();
        chk("abort_count", 32'(got.size()), 32'd5);
        check_bytes("abort", 0, 5, 80'h00_00_00_00_00_63_61_66_65_31);
        chk("abort_no_flush", 32'(flush_at.size()), 32'd0);
        // reset mid-word with a pending word, then a fresh full word
        begin_seq();
        start(32'h89ABCDEF);
        start(32'h77777777);
        step();
        step();
        rst = 1'b1;
        step();
        check_outputs_zero("midrst");
        rst = 1'b0;
        step();
        chk("midrst_idle_busy", 32'(sender_busy), 32'd0);
        run_vec("after_rst", '{32'h89ABCDEF, 1, 9, 80'h00_38_39_61_62_63_64_65_66_20, 10});
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
